// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory pins around dmem_arbiter.
// slave  : arbiter view (takes requests, drives grants and memory pins)
// master : environment view (requesters plus the data memory)
// Optional feature macro: DMEM_ARB_LOCK_EN adds the host bus-lock signal lock1.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          lock1;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, lock1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, lock1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );
`else
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between the CPU (requester 0)
// and the host loader (requester 1). Grants and memory pins are registered;
// read data is passed through from the memory during the response cycle.
// Optional feature macro: DMEM_ARB_LOCK_EN (host bus lock via lock1).
//
// state | meaning
// ------+------------------------------------------
// IDLE  | no access in flight
// ISSUE | memory access driven, grant pulse high
// RESP  | memory data returning, rvalid pulse high
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]    state_q;
  logic          last_q;
  logic          gnt0_q, gnt1_q;
  logic          rv0_q, rv1_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          any_req;
  logic          lock_win;
  logic          win1;

  // Winner selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    any_req  = bus.req0 | bus.req1;
`ifdef DMEM_ARB_LOCK_EN
    // With the lock held after a host grant, the host keeps the memory.
    lock_win = bus.lock1 & last_q;
`else
    lock_win = 1'b0;
`endif
    win1     = bus.req1 & (~bus.req0 | ~last_q | lock_win);
  end

  // Sequencer: decide in IDLE/RESP, drive memory in ISSUE, complete in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          rv0_q <= 1'b0;
          rv1_q <= 1'b0;
          if (any_req) begin
            state_q     <= ISSUE;
            gnt0_q      <= ~win1;
            gnt1_q      <= win1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win1 ? bus.we1    : bus.we0;
            mem_addr_q  <= win1 ? bus.addr1  : bus.addr0;
            mem_wdata_q <= win1 ? bus.wdata1 : bus.wdata0;
            last_q      <= win1;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          state_q  <= RESP;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          mem_en_q <= 1'b0;
          rv0_q    <= gnt0_q;
          rv1_q    <= gnt1_q;
        end
        default: begin
          state_q  <= IDLE;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          rv0_q    <= 1'b0;
          rv1_q    <= 1'b0;
          mem_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Output drive; read data only reaches the winner of a read, otherwise zero.
  always_comb begin
    bus.gnt0      = gnt0_q;
    bus.gnt1      = gnt1_q;
    bus.rvalid0   = rv0_q;
    bus.rvalid1   = rv1_q;
    bus.mem_en    = mem_en_q;
    bus.mem_we    = mem_we_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.rdata0    = (rv0_q && !mem_we_q) ? bus.mem_rdata : '0;
    bus.rdata1    = (rv1_q && !mem_we_q) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single-access vector table plus hand-written
// sequences for tie, sustained contention, reset mid-access and (optional) lock.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1, mrd;
    logic        eg1;
    logic        ewe;
    logic [31:0] eaddr, ewdata, erd0, erd1;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.mem_rdata = 0;
`ifdef DMEM_ARB_LOCK_EN
    bus.lock1 = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    //            name         r0 r1 w0 w1 a0            a1            d0            d1            mrd           eg1 ewe eaddr         ewdata        erd0          erd1
    vecs[0] = '{"cpu_read",   1, 0, 0, 0, 32'h10,       32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 0,  0,  32'h10,       32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1] = '{"host_write", 0, 1, 0, 1, 32'h0,        32'h40,       32'h0,        32'h55AA,     32'h12345678, 1,  1,  32'h40,       32'h55AA,     32'h0,        32'h0};
    vecs[2] = '{"tie_to_0",   1, 1, 0, 0, 32'h20,       32'h30,       32'h0,        32'h0,        32'hCAFE0001, 0,  0,  32'h20,       32'h0,        32'hCAFE0001, 32'h0};
    vecs[3] = '{"tie_to_1",   1, 1, 0, 0, 32'h20,       32'h30,       32'h0,        32'h0,        32'hBEEF0002, 1,  0,  32'h30,       32'h0,        32'h0,        32'hBEEF0002};
    vecs[4] = '{"cpu_write",  1, 0, 1, 0, 32'h7,        32'h0,        32'hA5A5A5A5, 32'h0,        32'h77777777, 0,  1,  32'h7,        32'hA5A5A5A5, 32'h0,        32'h0};
    vecs[5] = '{"host_maxad", 0, 1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 1,  0,  32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF};

    idle_inputs();
    rst_n = 0;
    #12;
    chk("rst_gnt",    {bus.gnt0, bus.gnt1}, 0);
    chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
    chk("rst_mem",    {bus.mem_en, bus.mem_we}, 0);
    chk("rst_addr",   bus.mem_addr, 0);
    chk("rst_wdata",  bus.mem_wdata, 0);
    chk("rst_rdata",  bus.rdata0 | bus.rdata1, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // Vector table: each entry is one isolated access from IDLE.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      bus.req0 = vecs[i].r0; bus.req1 = vecs[i].r1;
      bus.we0 = vecs[i].w0; bus.we1 = vecs[i].w1;
      bus.addr0 = vecs[i].a0; bus.addr1 = vecs[i].a1;
      bus.wdata0 = vecs[i].d0; bus.wdata1 = vecs[i].d1;
      @(posedge clk); #1;
      chk({vecs[i].name, "_gnt0"},  bus.gnt0, !vecs[i].eg1);
      chk({vecs[i].name, "_gnt1"},  bus.gnt1, vecs[i].eg1);
      chk({vecs[i].name, "_en"},    bus.mem_en, 1);
      chk({vecs[i].name, "_we"},    bus.mem_we, vecs[i].ewe);
      chk({vecs[i].name, "_addr"},  bus.mem_addr, vecs[i].eaddr);
      chk({vecs[i].name, "_wdata"}, bus.mem_wdata, vecs[i].ewdata);
      bus.req0 = 0; bus.req1 = 0;
      bus.mem_rdata = vecs[i].mrd;
      @(posedge clk); #1;
      chk({vecs[i].name, "_rv0"},   bus.rvalid0, !vecs[i].eg1);
      chk({vecs[i].name, "_rv1"},   bus.rvalid1, vecs[i].eg1);
      chk({vecs[i].name, "_rd0"},   bus.rdata0, vecs[i].erd0);
      chk({vecs[i].name, "_rd1"},   bus.rdata1, vecs[i].erd1);
      chk({vecs[i].name, "_en_r"},  bus.mem_en, 0);
      bus.mem_rdata = 0;
    end

    // Tie right after reset: CPU first, host two cycles later.
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 32'h100; bus.addr1 = 32'h200;
    @(posedge clk); #1;
    chk("tie_t1_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    chk("tie_t1_addr", bus.mem_addr, 32'h100);
    bus.req0 = 0;
    @(posedge clk); #1;
    chk("tie_t2_rv", {bus.rvalid1, bus.rvalid0}, 2'b01);
    @(posedge clk); #1;
    chk("tie_t3_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
    chk("tie_t3_addr", bus.mem_addr, 32'h200);
    bus.req1 = 0;
    @(posedge clk); #1;
    chk("tie_t4_rv", {bus.rvalid1, bus.rvalid0}, 2'b10);
    @(posedge clk); #1;
    chk("tie_t5_quiet", {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0}, 0);

    // Both requests held: 8 accesses alternating 0,1,..., one grant per 2 cycles.
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    begin
      logic prev_en;
      prev_en = 0;
      for (int k = 1; k <= 16; k++) begin
        @(posedge clk); #1;
        if (k % 2 == 1) begin
          chk($sformatf("held_gnt_%0d", k), {bus.gnt1, bus.gnt0},
              (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
        end else begin
          chk($sformatf("held_idle_%0d", k), {bus.gnt1, bus.gnt0, bus.mem_en}, 0);
        end
        chk($sformatf("held_adj_en_%0d", k), prev_en & bus.mem_en, 0);
        prev_en = bus.mem_en;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    @(posedge clk); #1;
    chk("held_stop", {bus.gnt1, bus.gnt0}, 0);

    // Reset asserted during ISSUE of a read.
    do_reset();
    bus.req0 = 1; bus.addr0 = 32'h10; bus.mem_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    chk("rst_issue_gnt", bus.gnt0, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_gnt", {bus.gnt1, bus.gnt0, bus.mem_en, bus.mem_we}, 0);
    chk("rst_mid_addr", bus.mem_addr, 0);
    chk("rst_mid_rv", {bus.rvalid1, bus.rvalid0}, 0);
    chk("rst_mid_rdata", bus.rdata0, 0);
    bus.req0 = 0;
    #2 rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_after_rv_%0d", k), {bus.rvalid1, bus.rvalid0, bus.mem_en}, 0);
    end
    bus.req0 = 1; bus.addr0 = 32'h11; bus.mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("rst_next_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    chk("rst_next_addr", bus.mem_addr, 32'h11);
    bus.req0 = 0;
    @(posedge clk); #1;
    chk("rst_next_rv", bus.rvalid0, 1);
    chk("rst_next_rd", bus.rdata0, 32'h0BADF00D);

`ifdef DMEM_ARB_LOCK_EN
    // Host wins once, then lock keeps the memory with the host while the CPU waits.
    do_reset();
    bus.req1 = 1;
    @(posedge clk); #1;
    chk("lock_c1_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
    bus.lock1 = 1; bus.req0 = 1;
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 3 || c == 5 || c == 7)
        chk($sformatf("lock_c%0d_gnt", c), {bus.gnt1, bus.gnt0}, 2'b10);
      else if (c == 9)
        chk($sformatf("lock_c%0d_gnt", c), {bus.gnt1, bus.gnt0}, 2'b01);
      else
        chk($sformatf("lock_c%0d_gnt", c), {bus.gnt1, bus.gnt0}, 2'b00);
      if (c == 7) begin
        bus.lock1 = 0; bus.req1 = 0;
      end
      if (c == 9) bus.req0 = 0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
